// File: rtl/distance_scan.sv
// Host-side scanner for the replica total-distance shift chain: rotates the chain
// once around and reports the minimum (with its replica id), maximum and sum.
module distance_scan #(
    parameter int replica_num = 32,
    parameter int dis_w       = 32,
    parameter int id_w        = $clog2(replica_num)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  opt_busy_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  distance_shift_o,
    output logic [dis_w-1:0]      distance_wdata_o,
    input  logic [dis_w-1:0]      distance_rdata_i,
    output logic [dis_w-1:0]      min_dis_o,
    output logic [id_w-1:0]       min_id_o,
    output logic [dis_w-1:0]      max_dis_o,
    output logic [dis_w+id_w-1:0] sum_dis_o
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FIN
    } state_t;

    localparam logic [id_w-1:0] LastCnt = id_w'(replica_num - 1);

    state_t                state_q;
    logic [id_w-1:0]       cnt_q;
    logic [dis_w-1:0]      minAcc_q, minAcc_d;
    logic [dis_w-1:0]      maxAcc_q, maxAcc_d;
    logic [id_w-1:0]       idAcc_q, idAcc_d;
    logic [dis_w+id_w-1:0] sumAcc_q, sumAcc_d;
    logic                  done_q;
    logic [dis_w-1:0]      minDis_q, maxDis_q;
    logic [id_w-1:0]       minId_q;
    logic [dis_w+id_w-1:0] sumDis_q;

    // Ids are visited tail-first (descending), so "<=" lets a later, lower id win ties.
    always_comb begin
        minAcc_d = minAcc_q;
        idAcc_d  = idAcc_q;
        maxAcc_d = maxAcc_q;
        sumAcc_d = sumAcc_q + {{id_w{1'b0}}, distance_rdata_i};
        if (distance_rdata_i <= minAcc_q) begin
            minAcc_d = distance_rdata_i;
            idAcc_d  = LastCnt - cnt_q;
        end
        if (distance_rdata_i > maxAcc_q) begin
            maxAcc_d = distance_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            minAcc_q <= '1;
            maxAcc_q <= '0;
            idAcc_q  <= '0;
            sumAcc_q <= '0;
            done_q   <= 1'b0;
            minDis_q <= '0;
            maxDis_q <= '0;
            minId_q  <= '0;
            sumDis_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !opt_busy_i) begin
                        state_q  <= SCAN;
                        cnt_q    <= '0;
                        minAcc_q <= '1;
                        maxAcc_q <= '0;
                        idAcc_q  <= '0;
                        sumAcc_q <= '0;
                    end
                end
                SCAN: begin
                    minAcc_q <= minAcc_d;
                    maxAcc_q <= maxAcc_d;
                    idAcc_q  <= idAcc_d;
                    sumAcc_q <= sumAcc_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    minDis_q <= minAcc_q;
                    maxDis_q <= maxAcc_q;
                    minId_q  <= idAcc_q;
                    sumDis_q <= sumAcc_q;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tail value is fed straight back to the head so the chain ends where it began.
    assign distance_shift_o = (state_q == SCAN);
    assign distance_wdata_o = (state_q == SCAN) ? distance_rdata_i : '0;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;
    assign min_dis_o        = minDis_q;
    assign max_dis_o        = maxDis_q;
    assign min_id_o         = minId_q;
    assign sum_dis_o        = sumDis_q;

endmodule

// File: tb/tb_distance_scan.sv
// Directed bench for distance_scan with a 4-deep behavioural model of the distance chain.
module tb_distance_scan;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          optBusy;
   logic          busy;
   logic          done;
   logic          shift;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic [DW-1:0] minDis;
   logic [IW-1:0] minId;
   logic [DW-1:0] maxDis;
   logic [DW+IW-1:0] sumDis;

   logic [DW-1:0] chain [N];
   logic [DW-1:0] loadVals [N];
   logic          loadEn;

   int assertCount = 0;
   int failCount   = 0;
   int shiftCount  = 0;
   int doneCount   = 0;
   int shiftBase;
   int doneBase;
   int latency;

   distance_scan #(.replica_num(N), .dis_w(DW)) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .start_i         (start),
      .opt_busy_i      (optBusy),
      .busy_o          (busy),
      .done_o          (done),
      .distance_shift_o(shift),
      .distance_wdata_o(wdata),
      .distance_rdata_i(rdata),
      .min_dis_o       (minDis),
      .min_id_o        (minId),
      .max_dis_o       (maxDis),
      .sum_dis_o       (sumDis)
   );

   always #5 clk = ~clk;

   // Chain model: element N-1 is the tail; a shift moves every element one place toward it.
   always @(posedge clk) begin
      if (loadEn) begin
         for (int i = 0; i < N; i++) chain[i] <= loadVals[i];
      end else if (shift) begin
         chain[0] <= wdata;
         for (int i = 1; i < N; i++) chain[i] <= chain[i-1];
      end
   end

   assign rdata = chain[N-1];

   // Event counters used to confirm exact shift counts and single done pulses.
   always @(posedge clk) begin
      if (shift) shiftCount <= shiftCount + 1;
      if (done)  doneCount  <= doneCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResults(input string tag, input logic [DW-1:0] minE, input logic [IW-1:0] idE,
                               input logic [DW-1:0] maxE, input logic [DW+IW-1:0] sumE);
      checkOutput({tag, ".min"}, 64'(minDis), 64'(minE));
      checkOutput({tag, ".id"},  64'(minId),  64'(idE));
      checkOutput({tag, ".max"}, 64'(maxDis), 64'(maxE));
      checkOutput({tag, ".sum"}, 64'(sumDis), 64'(sumE));
   endtask

   task automatic loadChain(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                            input logic [DW-1:0] r2, input logic [DW-1:0] r3);
      loadVals[0] = r0;
      loadVals[1] = r1;
      loadVals[2] = r2;
      loadVals[3] = r3;
      loadEn = 1'b1;
      @(negedge clk);
      loadEn = 1'b0;
   endtask

   // Pulses start for one cycle; returns at the negedge of the first cycle after acceptance.
   task automatic applyStimulus();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts cycles after start acceptance until done is seen, bounded so a dead DUT cannot hang.
   task automatic waitDone(input int fromCycle, output int lat);
      lat = fromCycle;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      optBusy = 1'b0;
      loadEn  = 1'b0;
      for (int i = 0; i < N; i++) loadVals[i] = '0;

      repeat (2) @(negedge clk);
      checkOutput("rst.busy",  64'(busy),   64'd0);
      checkOutput("rst.done",  64'(done),   64'd0);
      checkOutput("rst.shift", 64'(shift),  64'd0);
      checkOutput("rst.wdata", 64'(wdata),  64'd0);
      checkResults("rst", 32'd0, 2'd0, 32'd0, 34'd0);

      reset = 1'b1;
      shiftBase = shiftCount;
      repeat (100) @(negedge clk);
      checkOutput("idle.shifts", 64'(shiftCount - shiftBase), 64'd0);

      // Basic scan: minimum 7 appears at ids 3 and 1, lowest id wins.
      loadChain(32'd10, 32'd7, 32'd25, 32'd7);
      shiftBase = shiftCount;
      doneBase  = doneCount;
      applyStimulus();
      checkOutput("basic.wdataPass", 64'(wdata), 64'd7);
      waitDone(1, latency);
      checkOutput("basic.latency", 64'(latency), 64'd6);
      checkOutput("basic.shifts", 64'(shiftCount - shiftBase), 64'd4);
      checkResults("basic", 32'd7, 2'd1, 32'd25, 34'd49);
      @(negedge clk);
      checkOutput("basic.donePulse", 64'(done), 64'd0);
      checkOutput("basic.chainR0", 64'(chain[0]), 64'd10);
      checkOutput("basic.chainR2", 64'(chain[2]), 64'd25);

      // Rescan of the untouched chain must reproduce the same results.
      applyStimulus();
      waitDone(1, latency);
      checkOutput("rescan.latency", 64'(latency), 64'd6);
      checkResults("rescan", 32'd7, 2'd1, 32'd25, 34'd49);

      // Extremes: sum exceeds dis_w and must land in the extra id_w bits.
      loadChain(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus();
      waitDone(1, latency);
      checkOutput("bound.latency", 64'(latency), 64'd6);
      checkResults("bound", 32'd0, 2'd0, 32'hFFFF_FFFF, 34'h2_FFFF_FFFD);

      // Start while the array optimises is dropped.
      loadChain(32'd10, 32'd7, 32'd25, 32'd7);
      optBusy   = 1'b1;
      shiftBase = shiftCount;
      doneBase  = doneCount;
      applyStimulus();
      repeat (10) @(negedge clk);
      optBusy = 1'b0;
      checkOutput("gate.shifts", 64'(shiftCount - shiftBase), 64'd0);
      checkOutput("gate.dones",  64'(doneCount - doneBase),   64'd0);
      checkOutput("gate.busy",   64'(busy),                   64'd0);
      checkResults("gate", 32'hFFFF_FFFF & 32'd0, 2'd0, 32'hFFFF_FFFF, 34'h2_FFFF_FFFD);

      // Repeated start mid-scan plus opt_busy rising mid-scan: both ignored.
      shiftBase = shiftCount;
      doneBase  = doneCount;
      applyStimulus();
      @(negedge clk);
      start   = 1'b1;
      optBusy = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("mid.busy", 64'(busy), 64'd1);
      waitDone(3, latency);
      optBusy = 1'b0;
      checkOutput("mid.latency", 64'(latency), 64'd6);
      repeat (8) @(negedge clk);
      checkOutput("mid.shifts", 64'(shiftCount - shiftBase), 64'd4);
      checkOutput("mid.dones",  64'(doneCount - doneBase),   64'd1);
      checkResults("mid", 32'd7, 2'd1, 32'd25, 34'd49);

      // Back-to-back: start issued in the done cycle.
      applyStimulus();
      waitDone(1, latency);
      doneBase = doneCount;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b.shiftNow", 64'(shift), 64'd1);
      waitDone(1, latency);
      checkOutput("b2b.latency", 64'(latency), 64'd6);
      checkResults("b2b", 32'd7, 2'd1, 32'd25, 34'd49);

      // Reset asserted in scan cycle 2 aborts with everything cleared.
      @(negedge clk);
      doneBase = doneCount;
      applyStimulus();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checkOutput("abort.busy",  64'(busy),  64'd0);
      checkOutput("abort.shift", 64'(shift), 64'd0);
      checkResults("abort", 32'd0, 2'd0, 32'd0, 34'd0);
      repeat (10) @(negedge clk);
      checkOutput("abort.dones", 64'(doneCount - doneBase), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
